// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two line buffers feed a column-shift window, border samples replicate the centre.
// Build option WINDOW_GEN_GRAY_EN: neighbour samples become luma (R + 2G + B) >> 2 instead of blue.
module window_gen_3x3 #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_in,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [23:0] RGB_center,
    output logic [7:0]  top,
    output logic [7:0]  bot,
    output logic [7:0]  left,
    output logic [7:0]  right,
    output logic [7:0]  top_left,
    output logic [7:0]  top_right,
    output logic [7:0]  bot_left,
    output logic [7:0]  bot_right,
    output logic        frame_done
);
    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, PRIME, STREAM, FLUSH, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   in_col_q, out_col_q;
    logic [RW-1:0]   in_row_q, out_row_q;
    logic            all_formed_q, win_valid_q, frame_done_q;
    logic [23:0]     lb_a_q [WIDTH];
    logic [23:0]     lb_b_q [WIDTH];
    // Sample columns for the two newest pixels: [2] = row+1, [1] = row, [0] = row-1
    logic [2:0][7:0] s1_q, s2_q;
    logic [23:0]     mid2_q;
    logic [23:0]     center_q;
    logic [7:0]      top_q, bot_q, left_q, right_q, tl_q, tr_q, bl_q, br_q;

    logic            pix_xfer, win_xfer, form, shift;
    logic [23:0]     rd_a;
    logic [2:0][7:0] ns;
    logic [7:0]      sc;
    logic            no_top, no_bot, no_l, no_r;
    logic [7:0]      top_d, bot_d, left_d, right_d, tl_d, tr_d, bl_d, br_d;

    function automatic logic [7:0] samp(input logic [23:0] p);
`ifdef WINDOW_GEN_GRAY_EN
        logic [9:0] sum;
        sum = {2'b00, p[23:16]} + {1'b0, p[15:8], 1'b0} + {2'b00, p[7:0]};
        return sum[9:2];
`else
        return p[7:0];
`endif
    endfunction

    always_comb begin
        pix_ready = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE, PRIME: pix_ready = 1'b1;
                STREAM:      pix_ready = !win_valid_q || win_ready;
                default:     pix_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        pix_xfer = pix_valid && pix_ready;
        win_xfer = win_valid_q && win_ready;
        form     = (state_q == STREAM && pix_xfer) ||
                   (state_q == FLUSH && !all_formed_q && (!win_valid_q || win_ready));
        shift    = pix_xfer || form;
        rd_a     = lb_a_q[in_col_q];
        // In FLUSH the top sample of the incoming column is always border-replaced, so pix_in is a don't-care
        ns       = {samp(pix_in), samp(rd_a), samp(lb_b_q[in_col_q])};
        sc       = s2_q[1];
        no_top   = (out_row_q == ROW_LAST);
        no_bot   = (out_row_q == '0);
        no_l     = (out_col_q == '0);
        no_r     = (out_col_q == COL_LAST);
        tl_d     = (no_top || no_l) ? sc : s1_q[2];
        top_d    = no_top           ? sc : s2_q[2];
        tr_d     = (no_top || no_r) ? sc : ns[2];
        left_d   = no_l             ? sc : s1_q[1];
        right_d  = no_r             ? sc : ns[1];
        bl_d     = (no_bot || no_l) ? sc : s1_q[0];
        bot_d    = no_bot           ? sc : s2_q[0];
        br_d     = (no_bot || no_r) ? sc : ns[0];
    end

    always_ff @(posedge clk) begin
        if (shift && state_q != FLUSH) begin
            lb_a_q[in_col_q] <= pix_in;
            lb_b_q[in_col_q] <= rd_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            in_col_q     <= '0;
            in_row_q     <= '0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            all_formed_q <= 1'b0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            s1_q         <= '0;
            s2_q         <= '0;
            mid2_q       <= '0;
            center_q     <= '0;
            top_q        <= '0;
            bot_q        <= '0;
            left_q       <= '0;
            right_q      <= '0;
            tl_q         <= '0;
            tr_q         <= '0;
            bl_q         <= '0;
            br_q         <= '0;
        end else begin
            if (shift) begin
                s1_q   <= s2_q;
                s2_q   <= ns;
                mid2_q <= rd_a;
                if (in_col_q == COL_LAST) begin
                    in_col_q <= '0;
                    if (in_row_q != ROW_LAST) in_row_q <= in_row_q + 1'b1;
                end else begin
                    in_col_q <= in_col_q + 1'b1;
                end
            end
            if (form) begin
                center_q    <= mid2_q;
                top_q       <= top_d;
                bot_q       <= bot_d;
                left_q      <= left_d;
                right_q     <= right_d;
                tl_q        <= tl_d;
                tr_q        <= tr_d;
                bl_q        <= bl_d;
                br_q        <= br_d;
                win_valid_q <= 1'b1;
                if (out_col_q == COL_LAST) begin
                    out_col_q <= '0;
                    if (out_row_q == ROW_LAST) all_formed_q <= 1'b1;
                    else                       out_row_q    <= out_row_q + 1'b1;
                end else begin
                    out_col_q <= out_col_q + 1'b1;
                end
            end else if (win_xfer) begin
                win_valid_q <= 1'b0;
            end
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE:   if (pix_xfer) state_q <= PRIME;
                PRIME:  if (pix_xfer && in_row_q == RW'(1) && in_col_q == '0) state_q <= STREAM;
                STREAM: if (pix_xfer && in_row_q == ROW_LAST && in_col_q == COL_LAST) state_q <= FLUSH;
                FLUSH: begin
                    if (win_xfer && all_formed_q) begin
                        state_q      <= DONE;
                        frame_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    in_col_q     <= '0;
                    in_row_q     <= '0;
                    out_col_q    <= '0;
                    out_row_q    <= '0;
                    all_formed_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign RGB_center = center_q;
    assign top        = top_q;
    assign bot        = bot_q;
    assign left       = left_q;
    assign right      = right_q;
    assign top_left   = tl_q;
    assign top_right  = tr_q;
    assign bot_left   = bl_q;
    assign bot_right  = br_q;
endmodule
